id_ex_pipe_reg: RTL and testbench

//   ID/EX pipeline register and EX-stage operand selector for the 5-stage CPU. Captures decoded

---
 rtl/id_ex_pipe_reg.sv | 134 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Holds one decoded instruction. ALU operands are selected combinationally from the held fields
// and the current EX/MEM and MEM/WB writeback buses.
module id_ex_pipe_reg #(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           stall,
    input  logic           flush,
    input  logic           d_valid,
    input  logic           d_wreg,
    input  logic           d_m2reg,
    input  logic           d_wmem,
    input  logic           d_aluimm,
    input  logic           d_shift,
    input  logic           d_jal,
    input  logic [2:0]     d_aluc,
    input  logic           d_use_rs,
    input  logic           d_use_rt,
    input  logic [RAW-1:0] d_rs,
    input  logic [RAW-1:0] d_rt,
    input  logic [RAW-1:0] d_rn,
    input  logic [DW-1:0]  d_qa,
    input  logic [DW-1:0]  d_qb,
    input  logic [DW-1:0]  d_imm,
    input  logic [4:0]     d_sa,
    input  logic [DW-1:0]  d_pc4,
    input  logic           m_wreg,
    input  logic           m_m2reg,
    input  logic [RAW-1:0] m_rn,
    input  logic [DW-1:0]  m_alu,
    input  logic           w_wreg,
    input  logic [RAW-1:0] w_rn,
    input  logic [DW-1:0]  w_data,
    output logic [DW-1:0]  e_alua,
    output logic [DW-1:0]  e_alub,
    output logic [2:0]     e_aluc,
    output logic [DW-1:0]  e_store,
    output logic           e_valid,
    output logic           e_wreg,
    output logic           e_m2reg,
    output logic           e_wmem,
    output logic           e_jal,
    output logic [RAW-1:0] e_rn,
    output logic [DW-1:0]  e_pc8,
    output logic           load_use
);

    logic [RAW-1:0] rs_q, rt_q;
    logic [DW-1:0]  qa_q, qb_q, imm_q;
    logic [4:0]     sa_q;
    logic           aluimm_q, shift_q;
    logic [DW-1:0]  fwd_a, fwd_b;

    // NOTE: state registers use non-blocking assignments so every field samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            e_valid  <= 1'b0;
            e_wreg   <= 1'b0;
            e_m2reg  <= 1'b0;
            e_wmem   <= 1'b0;
            e_jal    <= 1'b0;
            e_aluc   <= 3'b000;
            e_rn     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            qa_q     <= '0;
            qb_q     <= '0;
            imm_q    <= '0;
            sa_q     <= '0;
            e_pc8    <= '0;
            aluimm_q <= 1'b0;
            shift_q  <= 1'b0;
        end else if (!stall) begin
            // A slot without a real instruction must never write state downstream.
            e_valid  <= d_valid;
            e_wreg   <= d_valid & d_wreg;
            e_m2reg  <= d_valid & d_m2reg;
            e_wmem   <= d_valid & d_wmem;
            e_jal    <= d_valid & d_jal;
            e_aluc   <= d_aluc;
            e_rn     <= d_rn;
            rs_q     <= d_rs;
            rt_q     <= d_rt;
            qa_q     <= d_qa;
            qb_q     <= d_qb;
            imm_q    <= d_imm;
            sa_q     <= d_sa;
            e_pc8    <= d_pc4 + DW'(4);
            aluimm_q <= d_aluimm;
            shift_q  <= d_shift;
        end
    end

    // Loads in EX/MEM are not forwarded from here; load_use keeps that case from arising.
    function automatic logic [DW-1:0] forward(
        input logic [RAW-1:0] src,
        input logic [DW-1:0]  rf_val,
        input logic           mw,
        input logic           mm2r,
        input logic [RAW-1:0] mrn,
        input logic [DW-1:0]  malu,
        input logic           ww,
        input logic [RAW-1:0] wrn,
        input logic [DW-1:0]  wdat
    );
        if (src == '0)
            return '0;
        else if (mw && !mm2r && mrn == src)
            return malu;
        else if (ww && wrn == src)
            return wdat;
        else
            return rf_val;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        fwd_a = forward(rs_q, qa_q, m_wreg, m_m2reg, m_rn, m_alu, w_wreg, w_rn, w_data);
        fwd_b = forward(rt_q, qb_q, m_wreg, m_m2reg, m_rn, m_alu, w_wreg, w_rn, w_data);
    end

    assign e_alua  = shift_q ? {{(DW-5){1'b0}}, sa_q} : fwd_a;
    assign e_alub  = aluimm_q ? imm_q : fwd_b;
    assign e_store = fwd_b;

    assign load_use = e_valid && e_wreg && e_m2reg && (e_rn != '0) &&
                      ((d_use_rs && d_rs == e_rn) || (d_use_rt && d_rt == e_rn));

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios followed by random traffic,
// all compared against a record-based model of the EX slot.
module tb_id_ex_pipe_reg;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic        d_valid, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal;
    logic [2:0]  d_aluc;
    logic        d_use_rs, d_use_rt;
    logic [4:0]  d_rs, d_rt, d_rn, d_sa;
    logic [31:0] d_qa, d_qb, d_imm, d_pc4;
    logic        m_wreg, m_m2reg, w_wreg;
    logic [4:0]  m_rn, w_rn;
    logic [31:0] m_alu, w_data;
    logic [31:0] e_alua, e_alub, e_store, e_pc8;
    logic [2:0]  e_aluc;
    logic        e_valid, e_wreg, e_m2reg, e_wmem, e_jal, load_use;
    logic [4:0]  e_rn;

    int checks = 0;
    int failures = 0;

    id_ex_pipe_reg #(.DW(32), .RAW(5)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
        .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal), .d_aluc(d_aluc),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
        .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_sa(d_sa), .d_pc4(d_pc4),
        .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu),
        .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
        .e_alua(e_alua), .e_alub(e_alub), .e_aluc(e_aluc), .e_store(e_store),
        .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
        .e_jal(e_jal), .e_rn(e_rn), .e_pc8(e_pc8), .load_use(load_use)
    );

    always #5 clock = ~clock;

    // Reference picture of the instruction sitting in EX.
    typedef struct {
        bit        valid, wreg, m2reg, wmem, jal, aluimm, shift;
        bit [2:0]  aluc;
        bit [4:0]  rn, rs, rt, sa;
        bit [31:0] qa, qb, imm, pc8;
    } slot_t;

    slot_t ex;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] rf);
        if (r == 0) return 32'd0;
        if (m_wreg && !m_m2reg && m_rn == r) return m_alu;
        if (w_wreg && w_rn == r) return w_data;
        return rf;
    endfunction

    task automatic model_edge();
        if (reset || flush) begin
            ex = '{default: 0};
        end else if (!stall) begin
            ex.valid  = d_valid;
            ex.wreg   = d_valid && d_wreg;
            ex.m2reg  = d_valid && d_m2reg;
            ex.wmem   = d_valid && d_wmem;
            ex.jal    = d_valid && d_jal;
            ex.aluimm = d_aluimm;
            ex.shift  = d_shift;
            ex.aluc   = d_aluc;
            ex.rn     = d_rn;
            ex.rs     = d_rs;
            ex.rt     = d_rt;
            ex.sa     = d_sa;
            ex.qa     = d_qa;
            ex.qb     = d_qb;
            ex.imm    = d_imm;
            ex.pc8    = d_pc4 + 32'd4;
        end
    endtask

    task automatic check_all(input string where);
        bit lu;
        lu = ex.valid && ex.wreg && ex.m2reg && ex.rn != 0 &&
             ((d_use_rs && d_rs == ex.rn) || (d_use_rt && d_rt == ex.rn));
        check({where, ".alua"},  e_alua,  ex.shift ? {27'd0, ex.sa} : operand(ex.rs, ex.qa));
        check({where, ".alub"},  e_alub,  ex.aluimm ? ex.imm : operand(ex.rt, ex.qb));
        check({where, ".store"}, e_store, operand(ex.rt, ex.qb));
        check({where, ".aluc"},  {29'd0, e_aluc}, {29'd0, ex.aluc});
        check({where, ".ctl"},   {27'd0, e_valid, e_wreg, e_m2reg, e_wmem, e_jal},
                                 {27'd0, ex.valid, ex.wreg, ex.m2reg, ex.wmem, ex.jal});
        check({where, ".rn"},    {27'd0, e_rn}, {27'd0, ex.rn});
        check({where, ".pc8"},   e_pc8, ex.pc8);
        check({where, ".load_use"}, {31'd0, load_use}, {31'd0, lu});
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        {reset, stall, flush} = '0;
        {d_valid, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal} = '0;
        {d_use_rs, d_use_rt} = '0;
        d_aluc = '0; d_rs = '0; d_rt = '0; d_rn = '0; d_sa = '0;
        d_qa = '0; d_qb = '0; d_imm = '0; d_pc4 = '0;
        {m_wreg, m_m2reg, w_wreg} = '0;
        m_rn = '0; w_rn = '0; m_alu = '0; w_data = '0;
    endtask

    task automatic random_inputs(input int reset_pct, input int flush_pct, input int stall_pct);
        reset    = ($urandom_range(0, 99) < reset_pct);
        flush    = ($urandom_range(0, 99) < flush_pct);
        stall    = ($urandom_range(0, 99) < stall_pct);
        d_valid  = ($urandom_range(0, 9) != 0);
        {d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal} = 6'($urandom);
        {d_use_rs, d_use_rt} = 2'($urandom);
        d_aluc   = 3'($urandom);
        // Narrow register range so forwarding and hazard matches happen often.
        d_rs     = 5'($urandom_range(0, 3));
        d_rt     = 5'($urandom_range(0, 3));
        d_rn     = 5'($urandom_range(0, 3));
        d_sa     = 5'($urandom);
        d_qa     = $urandom;
        d_qb     = $urandom;
        d_imm    = $urandom;
        d_pc4    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        {m_wreg, m_m2reg, w_wreg} = 3'($urandom);
        m_rn     = 5'($urandom_range(0, 3));
        w_rn     = 5'($urandom_range(0, 3));
        m_alu    = $urandom;
        w_data   = $urandom;
    endtask

    initial begin
        ex = '{default: 0};
        clear_inputs();

        // Reset with busy inputs must leave an empty slot.
        random_inputs(0, 0, 0);
        d_valid = 1'b1; d_wreg = 1'b1; d_m2reg = 1'b1; d_rn = 5'd9;
        reset = 1'b1;
        tick();
        check("reset.alua", e_alua, 32'd0);
        check("reset.valid", {31'd0, e_valid}, 32'd0);
        check("reset.pc8", e_pc8, 32'd0);
        check_all("reset");

        // add r3,r1,r2 with no forwarding.
        clear_inputs();
        d_valid = 1'b1; d_wreg = 1'b1; d_use_rs = 1'b1; d_use_rt = 1'b1;
        d_rs = 5'd1; d_rt = 5'd2; d_rn = 5'd3; d_qa = 32'd5; d_qb = 32'd7;
        tick();
        check("add.alua", e_alua, 32'd5);
        check("add.alub", e_alub, 32'd7);
        check("add.aluc", {29'd0, e_aluc}, 32'd0);
        check_all("add");

        // Forwarding priority on rs=4.
        clear_inputs();
        d_valid = 1'b1; d_rs = 5'd4; d_qa = 32'h99;
        tick();
        m_wreg = 1'b1; m_rn = 5'd4; m_alu = 32'h11;
        w_wreg = 1'b1; w_rn = 5'd4; w_data = 32'h22;
        #1 check("fwd.mem", e_alua, 32'h11);
        m_wreg = 1'b0;
        #1 check("fwd.wb", e_alua, 32'h22);
        m_m2reg = 1'b1; m_wreg = 1'b1;
        #1 check("fwd.mem_load_falls_through", e_alua, 32'h22);
        m_m2reg = 1'b0;
        d_rs = 5'd0; m_rn = 5'd0; w_rn = 5'd0; d_qa = 32'h55;
        tick();
        check("fwd.r0", e_alua, 32'd0);
        check_all("fwd");

        // Load-use hazard against lw r8 in EX.
        clear_inputs();
        d_valid = 1'b1; d_wreg = 1'b1; d_m2reg = 1'b1; d_rn = 5'd8;
        tick();
        d_rs = 5'd8; d_use_rs = 1'b1; d_rt = 5'd2; d_use_rt = 1'b1;
        #1 check("lu.hit", {31'd0, load_use}, 32'd1);
        d_use_rs = 1'b0;
        #1 check("lu.unused", {31'd0, load_use}, 32'd0);
        d_rt = 5'd8; d_use_rt = 1'b1;
        #1 check("lu.rt_hit", {31'd0, load_use}, 32'd1);

        // Stall holds the slot while ID keeps changing; flush overrides stall.
        clear_inputs();
        d_valid = 1'b1; d_wreg = 1'b1; d_rs = 5'd5; d_qa = 32'hA; d_rn = 5'd6; d_pc4 = 32'h100;
        tick();
        for (int i = 0; i < 3; i++) begin
            random_inputs(0, 0, 0);
            {m_wreg, w_wreg} = 2'b00;
            stall = 1'b1;
            tick();
            check("stall.alua", e_alua, 32'hA);
            check("stall.pc8", e_pc8, 32'h104);
            check_all("stall");
        end
        stall = 1'b1; flush = 1'b1;
        tick();
        check("flush.valid", {31'd0, e_valid}, 32'd0);
        check("flush.alua", e_alua, 32'd0);
        check_all("flush");

        // Shift amount, immediate and PC+8 wraparound.
        clear_inputs();
        d_valid = 1'b1; d_shift = 1'b1; d_sa = 5'd31; d_aluimm = 1'b1;
        d_imm = 32'hFFFF_FFFC; d_jal = 1'b1; d_pc4 = 32'hFFFF_FFFC; d_qa = 32'h1234;
        tick();
        check("sll.alua", e_alua, 32'h0000_001F);
        check("addi.alub", e_alub, 32'hFFFF_FFFC);
        check("jal.pc8", e_pc8, 32'h0000_0000);
        check("jal.ctl", {31'd0, e_jal}, 32'd1);
        check_all("imm");

        // Random traffic, checked before and after each edge.
        for (int i = 0; i < 500; i++) begin
            random_inputs(3, 10, 25);
            #1 check_all("rand.pre");
            tick();
            check_all("rand.post");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
